// File: rtl/memory_access_unit.sv
// Load/store unit: byte-addressed upstream requests to a word-wide responder, with read-modify-write for sub-word stores.
// Define MEM_ACCESS_TIMEOUT_EN to enable the responder timeout (TIMEOUT_CYCLES).
module memory_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        output_cmd_start,
    output logic        output_cmd_write,
    input  logic        input_cmd_ready,
    output logic [31:0] output_addr,
    output logic [31:0] output_wdata,
    input  logic [31:0] input_rdata,
    input  logic        input_rdata_valid
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        RESP
    } state_t;

    state_t      state;
    state_t      next_state;

    logic        write_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] addr_q;
    logic [15:0] wdata_q;

    logic        misaligned;
    logic        timeout_hit;
    logic [31:0] addr_n;
    logic        err_n;
    logic [31:0] rdata_n;
    logic [31:0] wdata_n;
    logic [31:0] merged;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign misaligned = (req_size == 2'd3)
                     || ((req_size == 2'd1) && req_addr[0])
                     || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

    // The address is taken live from the request port on the accepting cycle, latched afterwards.
    assign addr_n = (state == IDLE) ? req_addr : addr_q;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    // Per-state dwell counter, cleared whenever the state changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if ((next_state == state) && (state inside {RD_ISSUE, RD_WAIT, WR_ISSUE})) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        err_n      = 1'b0;
        rdata_n    = '0;
        wdata_n    = output_wdata;
        lane_b     = input_rdata[{addr_q[1:0], 3'b000} +: 8];
        lane_h     = input_rdata[{addr_q[1], 4'b0000} +: 16];
        merged     = input_rdata;
        if (size_q == 2'd0) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end

        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned) begin
                        next_state = RESP;
                        err_n      = 1'b1;
                    end else if (req_write && (req_size == 2'd2)) begin
                        next_state = WR_ISSUE;
                        wdata_n    = req_wdata;
                    end else begin
                        next_state = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                if (input_cmd_ready) begin
                    next_state = RD_WAIT;
                end else if (timeout_hit) begin
                    next_state = RESP;
                    err_n      = 1'b1;
                end
            end
            RD_WAIT: begin
                if (input_rdata_valid) begin
                    if (write_q) begin
                        next_state = WR_ISSUE;
                        wdata_n    = merged;
                    end else begin
                        next_state = RESP;
                        case (size_q)
                            2'd0:    rdata_n = signed_q ? {{24{lane_b[7]}}, lane_b} : {24'd0, lane_b};
                            2'd1:    rdata_n = signed_q ? {{16{lane_h[15]}}, lane_h} : {16'd0, lane_h};
                            default: rdata_n = input_rdata;
                        endcase
                    end
                end else if (timeout_hit) begin
                    next_state = RESP;
                    err_n      = 1'b1;
                end
            end
            WR_ISSUE: begin
                if (input_cmd_ready) begin
                    next_state = RESP;
                end else if (timeout_hit) begin
                    next_state = RESP;
                    err_n      = 1'b1;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q  <= 1'b0;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if ((state == IDLE) && req_valid) begin
            write_q  <= req_write;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata[15:0];
        end
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready        <= 1'b1;
            output_cmd_start <= 1'b0;
            output_cmd_write <= 1'b0;
            output_addr      <= '0;
            output_wdata     <= '0;
            resp_valid       <= 1'b0;
            resp_error       <= 1'b0;
            resp_rdata       <= '0;
        end else begin
            req_ready        <= (next_state == IDLE);
            output_cmd_start <= (next_state == RD_ISSUE) || (next_state == WR_ISSUE);
            output_cmd_write <= (next_state == WR_ISSUE);
            output_addr      <= (next_state inside {RD_ISSUE, RD_WAIT, WR_ISSUE})
                                ? {addr_n[31:2], 2'b00} : '0;
            output_wdata     <= (next_state == WR_ISSUE) ? wdata_n : '0;
            resp_valid       <= (next_state == RESP);
            resp_error       <= err_n;
            resp_rdata       <= rdata_n;
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: scoreboarded responses and downstream commands, bench acts as responder.
module tb_memory_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        output_cmd_start;
    logic        output_cmd_write;
    logic        input_cmd_ready;
    logic [31:0] output_addr;
    logic [31:0] output_wdata;
    logic [31:0] input_rdata;
    logic        input_rdata_valid;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    cmd_t  cmd_q[$];
    resp_t resp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    memory_access_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_size          (req_size),
        .req_signed        (req_signed),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .resp_valid        (resp_valid),
        .resp_rdata        (resp_rdata),
        .resp_error        (resp_error),
        .output_cmd_start  (output_cmd_start),
        .output_cmd_write  (output_cmd_write),
        .input_cmd_ready   (input_cmd_ready),
        .output_addr       (output_addr),
        .output_wdata      (output_wdata),
        .input_rdata       (input_rdata),
        .input_rdata_valid (input_rdata_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic exp_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        cmd_q.push_back('{wr, addr, wd});
    endtask

    // One upstream transaction; entered and left just after a falling edge with the unit idle.
    task automatic txn(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] mem,
                       input int stall, input bit give_rd, input int exp_lat,
                       input logic [31:0] exp_rd, input logic exp_err);
        int    n;
        int    stall_left;
        bit    done;
        bit    rd_pend;
        cmd_t  c;
        resp_t r;
        resp_q.push_back('{exp_rd, exp_err});
        chk1({tag, "_req_ready"}, req_ready, 1'b1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        @(negedge clk);
        req_valid  = 1'b0;
        req_write  = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        n = 1;
        done = 0;
        rd_pend = 0;
        stall_left = stall;
        while (!done && n <= 64) begin
            input_rdata_valid = 1'b0;
            input_rdata       = $urandom;
            input_cmd_ready   = 1'b0;
            if (rd_pend) begin
                input_rdata_valid = give_rd;
                input_rdata       = mem;
                rd_pend           = 0;
            end
            if (output_cmd_start) begin
                chk1({tag, "_cmd_expected"}, 1'(cmd_q.size() != 0), 1'b1);
                if (cmd_q.size() != 0) begin
                    c = cmd_q[0];
                    chk({tag, "_cmd_addr"}, output_addr, c.addr);
                    chk1({tag, "_cmd_write"}, output_cmd_write, c.write);
                    if (stall_left > 0) begin
                        stall_left--;
                        input_rdata_valid = 1'b1;
                    end else begin
                        input_cmd_ready = 1'b1;
                        void'(cmd_q.pop_front());
                        if (c.write) chk({tag, "_cmd_wdata"}, output_wdata, c.wdata);
                        else rd_pend = 1;
                    end
                end
            end
            if (resp_valid) begin
                r = resp_q.pop_front();
                chk({tag, "_rdata"}, resp_rdata, r.rdata);
                chk1({tag, "_error"}, resp_error, r.err);
                if (exp_lat >= 0) chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
                done = 1;
            end
            @(negedge clk);
            n++;
        end
        chk1({tag, "_completed"}, 1'(done), 1'b1);
        chk({tag, "_cmds_left"}, 32'(cmd_q.size()), 32'd0);
        input_cmd_ready   = 1'b0;
        input_rdata_valid = 1'b0;
        cmd_q.delete();
        resp_q.delete();
    endtask

    initial begin
        reset             = 1'b1;
        req_valid         = 1'b0;
        req_write         = 1'b0;
        req_size          = 2'd0;
        req_signed        = 1'b0;
        req_addr          = '0;
        req_wdata         = '0;
        input_cmd_ready   = 1'b0;
        input_rdata       = '0;
        input_rdata_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk1("rst_cmd_start", output_cmd_start, 1'b0);
        chk1("rst_cmd_write", output_cmd_write, 1'b0);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk1("rst_resp_error", resp_error, 1'b0);
        chk("rst_addr", output_addr, 32'h0);
        chk("rst_wdata", output_wdata, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        exp_cmd(1'b0, 32'h0000_0100, 32'h0);
        txn("ld_word", 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 1, 3, 32'hDEAD_BEEF, 1'b0);
        exp_cmd(1'b0, 32'h0000_0100, 32'h0);
        txn("ld_byte_s", 1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 32'h8011_2233, 0, 1, 3, 32'hFFFF_FF80, 1'b0);
        exp_cmd(1'b0, 32'h0000_0100, 32'h0);
        txn("ld_byte_u", 1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 32'h8011_2233, 0, 1, 3, 32'h0000_0080, 1'b0);
        exp_cmd(1'b0, 32'h0000_0200, 32'h0);
        exp_cmd(1'b1, 32'h0000_0200, 32'hABCD_3344);
        txn("st_half", 1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 32'h1122_3344, 0, 1, 4, 32'h0, 1'b0);
        txn("ld_misalign", 1'b0, 2'd2, 1'b0, 32'h0000_0001, 32'h0, 32'h0, 0, 1, 1, 32'h0, 1'b1);
        exp_cmd(1'b0, 32'h0000_0000, 32'h0);
        txn("ld_half_s", 1'b0, 2'd1, 1'b1, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 0, 1, 3, 32'hFFFF_8001, 1'b0);
        exp_cmd(1'b0, 32'h0000_0004, 32'h0);
        txn("ld_half_u", 1'b0, 2'd1, 1'b0, 32'h0000_0006, 32'h0, 32'hFEDC_1234, 0, 1, 3, 32'h0000_FEDC, 1'b0);
        exp_cmd(1'b0, 32'h0000_0010, 32'h0);
        exp_cmd(1'b1, 32'h0000_0010, 32'hAABB_5ADD);
        txn("st_byte", 1'b1, 2'd0, 1'b0, 32'h0000_0011, 32'h1234_565A, 32'hAABB_CCDD, 0, 1, 4, 32'h0, 1'b0);
        exp_cmd(1'b1, 32'h0000_0300, 32'h1234_5678);
        txn("st_word", 1'b1, 2'd2, 1'b0, 32'h0000_0300, 32'h1234_5678, 32'h0, 0, 1, 2, 32'h0, 1'b0);
        txn("size_rsvd", 1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 0, 1, 1, 32'h0, 1'b1);
        txn("half_odd", 1'b1, 2'd1, 1'b0, 32'h0000_0041, 32'h0, 32'h0, 0, 1, 1, 32'h0, 1'b1);
        exp_cmd(1'b0, 32'h0000_0104, 32'h0);
        txn("ld_word_s", 1'b0, 2'd2, 1'b1, 32'h0000_0104, 32'h0, 32'h8000_0000, 0, 1, 3, 32'h8000_0000, 1'b0);
        exp_cmd(1'b0, 32'h0000_0400, 32'h0);
        txn("ld_stall", 1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0, 32'h0BAD_F00D, 5, 1, 8, 32'h0BAD_F00D, 1'b0);
        exp_cmd(1'b0, 32'h0000_0800, 32'h0);
        exp_cmd(1'b1, 32'h0000_0800, 32'h5566_7788);
        txn("st_half_stall", 1'b1, 2'd1, 1'b0, 32'h0000_0800, 32'h0000_7788, 32'h5566_0000, 3, 1, -1, 32'h0, 1'b0);

        // Reset while waiting for read data: everything clears and the transaction is dropped.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'h0000_0500;
        @(negedge clk);
        req_valid       = 1'b0;
        input_cmd_ready = 1'b1;
        @(negedge clk);
        input_cmd_ready = 1'b0;
        chk("pre_rst_addr", output_addr, 32'h0000_0500);
        reset = 1'b1;
        #1;
        chk1("rst2_cmd_start", output_cmd_start, 1'b0);
        chk1("rst2_resp_valid", resp_valid, 1'b0);
        chk1("rst2_resp_error", resp_error, 1'b0);
        chk("rst2_addr", output_addr, 32'h0);
        chk("rst2_wdata", output_wdata, 32'h0);
        chk("rst2_rdata", resp_rdata, 32'h0);
        chk1("rst2_req_ready", req_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            input_cmd_ready   = 1'b1;
            input_rdata_valid = 1'b1;
            input_rdata       = 32'hCAFE_0000;
            @(negedge clk);
            chk1("post_rst_no_resp", resp_valid, 1'b0);
            chk1("post_rst_no_cmd", output_cmd_start, 1'b0);
        end
        input_cmd_ready   = 1'b0;
        input_rdata_valid = 1'b0;

        exp_cmd(1'b0, 32'h0000_0700, 32'h0);
        txn("ld_after_rst", 1'b0, 2'd0, 1'b0, 32'h0000_0701, 32'h0, 32'h0000_9900, 0, 1, 3, 32'h0000_0099, 1'b0);

`ifdef MEM_ACCESS_TIMEOUT_EN
        exp_cmd(1'b0, 32'h0000_0600, 32'h0);
        txn("timeout", 1'b0, 2'd2, 1'b0, 32'h0000_0600, 32'h0, 32'h0, 0, 0, 10, 32'h0, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
